// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM peripheral on the memory-mapped peripheral bus.
//
// One shared period counter, driven by an 8-bit prescaler, feeds CH compare
// channels. Edge-aligned (sawtooth) and center-aligned (triangle) counting are
// supported. PERIOD, DUTY and CTRL.MODE are written into shadow registers.
// Active copies reload only at a period end, or while the counter is idle
// (EN=0 or active period 0), so a running period is never torn.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   wr, cs   write strobe qualified by peripheral select
//   addr     byte address, word index = addr[5:2]
//   wdata    write data
//   rdata    combinational read data
//   pwm_out  registered PWM outputs, one per channel
//   irq      level interrupt, STATUS.PEF & CTRL.IRQEN
//
// Register map (word index):
//   0 CTRL    [0] EN, [1] MODE (0 edge, 1 center), [2] IRQEN, [8+i] POL[i]
//   1 PERIOD  [CW-1:0] shadow
//   2 PRESCALE[7:0] PS, tick every PS+1 clocks
//   3 STATUS  [0] PEF, write-1-to-clear
//   8+i DUTY[i] [CW-1:0] shadow, i < CH
module pwm_multi #(
  parameter int CH = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          cs,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [CH-1:0] pwm_out,
  output logic          irq
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  // Programmer-visible registers
  logic          r_en;
  logic          r_mode;
  logic          r_irqen;
  logic [CH-1:0] r_pol;
  logic [CW-1:0] r_period;
  logic [7:0]    r_ps;
  logic          r_pef;
  logic [CW-1:0] r_duty [CH];

  // Active copies used by the counter and compare logic
  logic [CW-1:0] r_perA;
  logic          r_modeA;
  logic [CW-1:0] r_dutyA [CH];

  // Counter state
  logic [CW-1:0] r_cnt;
  dir_t          r_dir;
  logic [7:0]    r_psCnt;
  logic [CH-1:0] r_pwm;

  logic          w_wr;
  logic [3:0]    w_idx;
  logic          w_run;
  logic          w_tick;
  logic          w_last;
  logic          w_pe;
  logic          w_reload;
  logic [CW-1:0] w_cntNext;
  dir_t          w_dirNext;
  logic [CH-1:0] w_active;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_wr     = wr & cs;
  assign w_idx    = addr[5:2];
  assign w_unused = ^{addr[31:6], addr[1:0], wdata};

  // The counter only runs with the block enabled and a non-zero active period.
  assign w_run    = r_en & (r_perA != '0);
  assign w_tick   = w_run & (r_psCnt == r_ps);
  assign w_last   = (r_cnt == r_perA - ONE);
  assign w_reload = w_pe | ~w_run;

  // Counter next state. Edge mode wraps at PER_A-1; center mode holds one tick
  // at each end so the triangle spans exactly 2*PER_A ticks and stays symmetric.
  always_comb begin
    w_cntNext = r_cnt;
    w_dirNext = r_dir;
    w_pe      = 1'b0;
    if (!w_run) begin
      w_cntNext = '0;
      w_dirNext = DIR_UP;
    end else if (w_tick) begin
      if (!r_modeA) begin
        if (w_last) begin
          w_cntNext = '0;
          w_pe      = 1'b1;
        end else begin
          w_cntNext = r_cnt + ONE;
        end
      end else if (r_dir == DIR_UP) begin
        if (w_last) begin
          w_dirNext = DIR_DOWN;
        end else begin
          w_cntNext = r_cnt + ONE;
        end
      end else begin
        if (r_cnt == '0) begin
          w_dirNext = DIR_UP;
          w_pe      = 1'b1;
        end else begin
          w_cntNext = r_cnt - ONE;
        end
      end
    end
  end

  // Counter, direction and prescaler registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_dir   <= DIR_UP;
      r_psCnt <= '0;
    end else begin
      r_cnt <= w_cntNext;
      r_dir <= w_dirNext;
      if (!w_run || (r_psCnt == r_ps)) begin
        r_psCnt <= '0;
      end else begin
        r_psCnt <= r_psCnt + 8'd1;
      end
    end
  end

  // Bus writes to the shadow registers. A period-end set of PEF beats a
  // simultaneous write-1-to-clear so no event is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en     <= 1'b0;
      r_mode   <= 1'b0;
      r_irqen  <= 1'b0;
      r_pol    <= '0;
      r_period <= '0;
      r_ps     <= '0;
      r_pef    <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_duty[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        case (w_idx)
          4'd0: begin
            r_en    <= wdata[0];
            r_mode  <= wdata[1];
            r_irqen <= wdata[2];
            r_pol   <= wdata[8 +: CH];
          end
          4'd1:    r_period <= wdata[CW-1:0];
          4'd2:    r_ps     <= wdata[7:0];
          default: ;
        endcase
      end
      for (int i = 0; i < CH; i++) begin
        if (w_wr && (w_idx == 4'(8 + i))) begin
          r_duty[i] <= wdata[CW-1:0];
        end
      end
      if (w_pe) begin
        r_pef <= 1'b1;
      end else if (w_wr && (w_idx == 4'd3) && wdata[0]) begin
        r_pef <= 1'b0;
      end
    end
  end

  // Active copies follow the shadows only at a period end or while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perA  <= '0;
      r_modeA <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_dutyA[i] <= '0;
      end
    end else if (w_reload) begin
      r_perA  <= r_period;
      r_modeA <= r_mode;
      for (int i = 0; i < CH; i++) begin
        r_dutyA[i] <= r_duty[i];
      end
    end
  end

  // Compare stage; DUTY >= PERIOD naturally yields 100% since cnt < PER_A.
  always_comb begin
    w_active = '0;
    for (int i = 0; i < CH; i++) begin
      w_active[i] = w_run & (r_cnt < r_dutyA[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_active ^ r_pol;
    end
  end

  // Read mux; unused bits and unmapped indices read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      4'd0: begin
        w_rdata[0]      = r_en;
        w_rdata[1]      = r_mode;
        w_rdata[2]      = r_irqen;
        w_rdata[8 +: CH] = r_pol;
      end
      4'd1:    w_rdata[CW-1:0] = r_period;
      4'd2:    w_rdata[7:0]    = r_ps;
      4'd3:    w_rdata[0]      = r_pef;
      default: ;
    endcase
    for (int i = 0; i < CH; i++) begin
      if (w_idx == 4'(8 + i)) begin
        w_rdata[CW-1:0] = r_duty[i];
      end
    end
  end

  assign rdata   = w_rdata;
  assign pwm_out = r_pwm;
  assign irq     = r_pef & r_irqen;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi (CH=4, CW=16).
// Registers are written from the falling edge, outputs are sampled 1 time
// unit after the rising edge, and reads use the combinational rdata path.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int CW = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          wr    = 1'b0;
  logic          cs    = 1'b0;
  logic [31:0]   addr  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [CH-1:0] pwm_out;
  logic          irq;

  int testsRun    = 0;
  int testsFailed = 0;

  pwm_multi #(.CH(CH), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .cs      (cs),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus write; the register updates on the next rising edge.
  task automatic applyStimulus(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    addr  = {26'd0, idx, 2'b00};
    wdata = data;
    wr    = 1'b1;
    cs    = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
    cs = 1'b0;
  endtask

  task automatic readReg(input logic [3:0] idx, output logic [31:0] d);
    addr = {26'd0, idx, 2'b00};
    #1;
    d = rdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    readReg(idx, d);
    checkOutput(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int highs [CH];
    int lows;
    int hi0;
    logic [7:0] centerPat;
    centerPat = 8'b1100_0011;

    // ---------------- reset state ----------------
    #2;
    checkOutput("rst_pwm", 32'(pwm_out), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkReg("rst_ctrl", 4'd0, 32'h0);
    checkReg("rst_status", 4'd3, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- edge mode, basic duty ----------------
    applyStimulus(4'd2, 32'd0);
    applyStimulus(4'd1, 32'd10);
    applyStimulus(4'd8, 32'd3);
    applyStimulus(4'd9, 32'd0);
    applyStimulus(4'd10, 32'd10);
    applyStimulus(4'd11, 32'd15);
    checkReg("period_shadow", 4'd1, 32'd10);
    checkReg("duty3_shadow", 4'd11, 32'd15);
    applyStimulus(4'd5, 32'hFFFF_FFFF);
    checkReg("unmapped_idx5", 4'd5, 32'h0);
    checkReg("duty_idx12_absent", 4'd12, 32'h0);
    applyStimulus(4'd0, 32'h1);
    checkReg("ctrl_readback", 4'd0, 32'h1);
    for (int c = 0; c < CH; c++) highs[c] = 0;
    for (int j = 1; j <= 20; j++) begin
      stepClk(1);
      for (int c = 0; c < CH; c++) highs[c] += int'(pwm_out[c]);
      if (j == 9)  checkReg("pef_before_end", 4'd3, 32'h0);
      if (j == 10) checkReg("pef_at_end", 4'd3, 32'h1);
    end
    checkOutput("edge_ch0_highs", 32'(highs[0]), 32'd6);
    checkOutput("edge_ch1_highs", 32'(highs[1]), 32'd0);
    checkOutput("edge_ch2_highs", 32'(highs[2]), 32'd20);
    checkOutput("edge_ch3_highs", 32'(highs[3]), 32'd20);
    applyStimulus(4'd3, 32'h1);
    checkReg("pef_w1c", 4'd3, 32'h0);
    stepClk(8);
    checkReg("pef_not_yet", 4'd3, 32'h0);
    stepClk(1);
    checkReg("pef_every_10", 4'd3, 32'h1);

    // ---------------- shadow update mid-period ----------------
    hi0 = 0;
    for (int j = 1; j <= 5; j++) begin
      stepClk(1);
      hi0 += int'(pwm_out[0]);
    end
    checkOutput("shadow_head_highs", 32'(hi0), 32'd3);
    applyStimulus(4'd8, 32'd7);
    checkReg("duty0_rd_now", 4'd8, 32'd7);
    checkOutput("shadow_pwm_c5", 32'(pwm_out[0]), 32'h0);
    applyStimulus(4'd1, 32'd20);
    checkReg("period_rd_now", 4'd1, 32'd20);
    checkOutput("shadow_pwm_c6", 32'(pwm_out[0]), 32'h0);
    hi0 = 0;
    for (int j = 8; j <= 10; j++) begin
      stepClk(1);
      hi0 += int'(pwm_out[0]);
    end
    checkOutput("shadow_tail_highs", 32'(hi0), 32'd0);
    hi0 = 0;
    for (int j = 11; j <= 30; j++) begin
      stepClk(1);
      hi0 += int'(pwm_out[0]);
    end
    checkOutput("new_period_highs", 32'(hi0), 32'd7);

    // ---------------- center mode ----------------
    applyStimulus(4'd0, 32'h0);
    applyStimulus(4'd1, 32'd4);
    applyStimulus(4'd8, 32'd2);
    applyStimulus(4'd3, 32'h1);
    applyStimulus(4'd0, 32'h2);
    applyStimulus(4'd0, 32'h3);
    checkReg("center_pef_clear", 4'd3, 32'h0);
    for (int j = 1; j <= 8; j++) begin
      stepClk(1);
      checkOutput($sformatf("center_pwm_%0d", j), 32'(pwm_out[0]), 32'(centerPat[j-1]));
      if (j == 7) checkReg("center_pef_7", 4'd3, 32'h0);
      if (j == 8) checkReg("center_pef_8", 4'd3, 32'h1);
    end
    applyStimulus(4'd3, 32'h1);
    checkReg("center_pef_w1c", 4'd3, 32'h0);
    stepClk(6);
    checkReg("center_pef_15", 4'd3, 32'h0);
    stepClk(1);
    checkReg("center_pef_16", 4'd3, 32'h1);

    // ---------------- prescale and polarity ----------------
    applyStimulus(4'd0, 32'h0);
    applyStimulus(4'd2, 32'd3);
    applyStimulus(4'd1, 32'd5);
    applyStimulus(4'd8, 32'd2);
    applyStimulus(4'd0, 32'h100);
    stepClk(1);
    checkOutput("pol_idle_level", 32'(pwm_out[0]), 32'h1);
    applyStimulus(4'd3, 32'h1);
    applyStimulus(4'd0, 32'h101);
    lows = 0;
    hi0  = 0;
    for (int j = 1; j <= 20; j++) begin
      stepClk(1);
      if (pwm_out[0]) hi0++;
      else lows++;
      if (j == 1)  checkOutput("ps_first_low", 32'(pwm_out[0]), 32'h0);
      if (j == 19) checkReg("ps_pef_19", 4'd3, 32'h0);
      if (j == 20) checkReg("ps_pef_20", 4'd3, 32'h1);
    end
    checkOutput("ps_low_count", 32'(lows), 32'd8);
    checkOutput("ps_high_count", 32'(hi0), 32'd12);
    applyStimulus(4'd0, 32'h100);
    stepClk(1);
    checkOutput("pol_disabled_out", 32'(pwm_out), 32'h1);

    // ---------------- interrupt ----------------
    applyStimulus(4'd2, 32'd0);
    applyStimulus(4'd1, 32'd4);
    applyStimulus(4'd3, 32'h1);
    applyStimulus(4'd0, 32'h5);
    stepClk(3);
    applyStimulus(4'd3, 32'h1);
    checkReg("irq_set_wins", 4'd3, 32'h1);
    checkOutput("irq_kept", 32'(irq), 32'h1);
    applyStimulus(4'd3, 32'h1);
    checkReg("irq_w1c_pef", 4'd3, 32'h0);
    checkOutput("irq_w1c_irq", 32'(irq), 32'h0);
    stepClk(3);
    checkReg("irq_next_pef", 4'd3, 32'h1);
    checkOutput("irq_next_irq", 32'(irq), 32'h1);
    applyStimulus(4'd0, 32'h1);
    checkOutput("irq_masked", 32'(irq), 32'h0);
    checkReg("irq_masked_pef", 4'd3, 32'h1);

    // ---------------- async reset, then PERIOD=0 ----------------
    applyStimulus(4'd0, 32'h101);
    stepClk(2);
    checkOutput("pre_rst_pwm3", 32'(pwm_out[3]), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("rst_async_pwm", 32'(pwm_out), 32'h0);
    checkOutput("rst_async_irq", 32'(irq), 32'h0);
    checkReg("rst_async_ctrl", 4'd0, 32'h0);
    checkReg("rst_async_period", 4'd1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(4'd0, 32'h105);
    stepClk(10);
    checkOutput("per0_pwm_pol", 32'(pwm_out), 32'h1);
    checkReg("per0_no_pef", 4'd3, 32'h0);
    checkOutput("per0_no_irq", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
